fifo_rd_stream: RTL

- Read-side drain stage that sits directly downstream of the async FIFO. It runs entirely in the read clock domain.
- Pops words from the FIFO read port, where data arrives one cycle after the pop, and presents them as a registered valid/ready stream.
- Buffers words in a 2-entry output buffer so that m_ready backpressure never loses data and throughput stays at one word per cycle.
- Frames the stream into fixed-length packets with a last flag and counts completed packets.

---
 rtl/async_fifo_pkg.sv | 10 +
 rtl/stream_skid_buf.sv | 58 +++++
 rtl/fifo_rd_stream.sv | 68 ++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared constants and types for the async FIFO read-side drain path.
package async_fifo_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int RD_LAT     = 1;
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;
endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 2-entry registered output buffer with write/pop/flush and occupancy.
module stream_skid_buf
    import async_fifo_pkg::*;
#(
    parameter int W = DATA_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         wr,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] rd_data,
    output logic [1:0]   occ
);
    occ_t         occ_q, occ_d;
    logic         head_q, head_d;
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         tail;
    logic         pop_ok;
    logic         wr_ok;

    // tail = head + occ (mod 2); at FULL it equals head, the slot a same-cycle pop frees
    always_comb begin
        pop_ok = pop && occ_q != OCC_EMPTY;
        wr_ok  = wr && !flush;
        tail   = head_q ^ occ_q[0];
        mem_d  = mem_q;
        if (wr_ok) mem_d[tail] = wr_data;
        head_d = flush ? 1'b0 : head_q ^ pop_ok;
        occ_d  = flush            ? OCC_EMPTY
               : (wr_ok && !pop_ok) ? (occ_q == OCC_EMPTY ? OCC_ONE : OCC_FULL)
               : (!wr_ok && pop_ok) ? (occ_q == OCC_FULL ? OCC_ONE : OCC_EMPTY)
               : occ_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q    <= OCC_EMPTY;
            head_q   <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            mem_q  <= mem_d;
        end
    end

    assign valid   = occ_q != OCC_EMPTY;
    assign rd_data = mem_q[head_q];
    assign occ     = occ_q;

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_ok && !pop_ok && occ_q == OCC_FULL));
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains the async FIFO read port into a framed valid/ready stream.
// Credit-based pops keep the 2-entry buffer from overflowing while sustaining one word per cycle.
module fifo_rd_stream
    import async_fifo_pkg::*;
#(
    parameter int Data_Width = DATA_W_DEF,
    parameter int PKT_LEN    = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rstn,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [Data_Width-1:0] fifo_data,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [Data_Width-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_W-1:0]      pkt_count
);
    localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

    logic             inflight_q, inflight_d;
    logic [15:0]      beat_q, beat_d;
    logic [CNT_W-1:0] pkt_q, pkt_d;
    logic [1:0]       occ;
    logic             pop_out;
    logic             wr;

    assign pop_out   = m_valid && m_ready;
    assign wr        = inflight_q && !flush;
    assign m_last    = m_valid && beat_q == LAST_BEAT;
    assign pkt_count = pkt_q;

    // Words already committed (buffered + in flight) minus the one leaving this cycle must stay below 2
    always_comb begin
        fifo_rd_en = rd_rstn && !fifo_empty && !flush &&
                     ({1'b0, occ} + {2'b00, inflight_q} < 3'd2 + {2'b00, pop_out});
        inflight_d = fifo_rd_en;
        beat_d     = (flush || (pop_out && m_last)) ? 16'd0 : beat_q + 16'(pop_out);
        pkt_d      = pkt_q + CNT_W'(pop_out && m_last);
    end

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            inflight_q <= 1'b0;
            beat_q     <= 16'd0;
            pkt_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            beat_q     <= beat_d;
            pkt_q      <= pkt_d;
        end
    end

    stream_skid_buf #(.W(Data_Width)) u_buf (
        .clk     (rd_clk),
        .rst_n   (rd_rstn),
        .flush   (flush),
        .wr      (wr),
        .wr_data (fifo_data),
        .pop     (pop_out),
        .valid   (m_valid),
        .rd_data (m_data),
        .occ     (occ)
    );
endmodule
